// File: rtl/bt_resp_rx.sv
// bt_resp_rx -- UART receiver and response-line parser for the RN-52 module.
//
// Receives 8N1 serial data on RX, assembles LF-terminated response lines and
// classifies each completed line as "AOK", "ERR" or other. The command
// sequencer uses the one-cycle resp_rcvd strobe to advance.
//
// Parameters:
//   BAUD_DIV  clk cycles per bit (default 434 = 50 MHz / 115200)
//   BUF_DEPTH leading characters of each line kept for classification (>= 3)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   RX         serial data from RN-52, idle high, asynchronous to clk
//   rx_data    last good received byte
//   rx_rdy     one-cycle strobe, rx_data valid
//   frame_err  one-cycle strobe, stop bit sampled low (byte discarded)
//   resp_rcvd  one-cycle strobe, non-empty line completed
//   resp_ok    last completed line began "AOK"
//   resp_err   last completed line began "ERR"
//   line_len   char count of last line, CR/LF excluded, saturates at 255
//   resp_to    (BT_RESP_TIMEOUT_EN only) one-cycle strobe, partial line
//              dropped after 20 bit times of silence
//
// Optional feature macro: BT_RESP_TIMEOUT_EN

module bt_resp_rx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       resp_rcvd,
  output logic       resp_ok,
  output logic       resp_err,
  output logic [7:0] line_len
`ifdef BT_RESP_TIMEOUT_EN
  ,
  output logic       resp_to
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } uart_state_e;

  // Counter expires at zero, so reload values are one less than the period.
  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'((BAUD_DIV / 2) - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // --------------------------------------------------------------------------
  // Input synchronizer, preset to idle so reset release never fakes a start.
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // UART receive FSM
  // --------------------------------------------------------------------------
  uart_state_e state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_rdy_q;
  logic        frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_rdy_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_q <= S_START;
            baud_q  <= HALF_RELOAD;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            if (!rx_sync_q) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
              baud_q    <= BIT_RELOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            baud_q  <= BIT_RELOAD;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_q == '0) begin
            if (rx_sync_q) begin
              rx_data_q <= shift_q;
              rx_rdy_q  <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_BREAK: begin
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Line assembler and classifier
  // --------------------------------------------------------------------------
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] line_buf_q [BUF_DEPTH];
  logic [7:0] line_buf_d [BUF_DEPTH];
  logic       resp_rcvd_q, resp_rcvd_d;
  logic       resp_ok_q, resp_ok_d;
  logic       resp_err_q, resp_err_d;
  logic [7:0] line_len_q, line_len_d;
  logic       is_aok, is_err;

  assign is_aok = (cnt_q >= 8'd3) && (line_buf_q[0] == 8'h41) &&
                  (line_buf_q[1] == 8'h4F) && (line_buf_q[2] == 8'h4B);
  assign is_err = (cnt_q >= 8'd3) && (line_buf_q[0] == 8'h45) &&
                  (line_buf_q[1] == 8'h52) && (line_buf_q[2] == 8'h52);

`ifdef BT_RESP_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 20 * BAUD_DIV;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            resp_to_q, resp_to_d;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    line_buf_d  = line_buf_q;
    resp_rcvd_d = 1'b0;
    resp_ok_d   = resp_ok_q;
    resp_err_d  = resp_err_q;
    line_len_d  = line_len_q;
`ifdef BT_RESP_TIMEOUT_EN
    idle_d      = '0;
    resp_to_d   = 1'b0;
`endif
    if (rx_rdy_q) begin
      if (rx_data_q == CH_CR) begin
        // CR carries no information for line framing
      end else if (rx_data_q == CH_LF) begin
        if (cnt_q != '0) begin
          resp_rcvd_d = 1'b1;
          line_len_d  = cnt_q;
          resp_ok_d   = is_aok;
          resp_err_d  = is_err;
          cnt_d       = '0;
          line_buf_d  = '{default: '0};
        end
      end else begin
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
          if (32'(cnt_q) == i) begin
            line_buf_d[i] = rx_data_q;
          end
        end
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
`ifdef BT_RESP_TIMEOUT_EN
    // Silence only counts while a partial line is pending and the receiver
    // is idle; leaving IDLE (start bit) or taking a byte restarts it.
    else if ((cnt_q != '0) && (state_q == S_IDLE)) begin
      if (idle_q == TO_W'(TO_CYCLES - 1)) begin
        resp_to_d  = 1'b1;
        cnt_d      = '0;
        line_buf_d = '{default: '0};
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      line_buf_q  <= '{default: '0};
      resp_rcvd_q <= 1'b0;
      resp_ok_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      line_len_q  <= '0;
`ifdef BT_RESP_TIMEOUT_EN
      idle_q      <= '0;
      resp_to_q   <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      line_buf_q  <= line_buf_d;
      resp_rcvd_q <= resp_rcvd_d;
      resp_ok_q   <= resp_ok_d;
      resp_err_q  <= resp_err_d;
      line_len_q  <= line_len_d;
`ifdef BT_RESP_TIMEOUT_EN
      idle_q      <= idle_d;
      resp_to_q   <= resp_to_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_rdy    = rx_rdy_q;
  assign frame_err = frame_err_q;
  assign resp_rcvd = resp_rcvd_q;
  assign resp_ok   = resp_ok_q;
  assign resp_err  = resp_err_q;
  assign line_len  = line_len_q;
`ifdef BT_RESP_TIMEOUT_EN
  assign resp_to   = resp_to_q;
`endif

endmodule

// File: tb/tb_bt_resp_rx.sv
// tb_bt_resp_rx -- self-checking bench for bt_resp_rx.
// Drives 8N1 frames on RX and compares the DUT against a line-level model:
// strobe counts, last good byte, and classification of each completed line.

module tb_bt_resp_rx;

  localparam int unsigned BAUD = 8;
  localparam int unsigned GAP  = 4;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frame_err;
  logic       resp_rcvd;
  logic       resp_ok;
  logic       resp_err;
  logic [7:0] line_len;
`ifdef BT_RESP_TIMEOUT_EN
  logic       resp_to;
`endif

  bt_resp_rx #(
    .BAUD_DIV (BAUD),
    .BUF_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .frame_err(frame_err),
    .resp_rcvd(resp_rcvd),
    .resp_ok  (resp_ok),
    .resp_err (resp_err),
    .line_len (line_len)
`ifdef BT_RESP_TIMEOUT_EN
    ,
    .resp_to  (resp_to)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // observed strobe counts, sampled away from the active edge
  int obs_rdy  = 0;
  int obs_fe   = 0;
  int obs_resp = 0;
  int obs_to   = 0;

  always @(negedge clk) begin
    if (rx_rdy)    obs_rdy++;
    if (frame_err) obs_fe++;
    if (resp_rcvd) obs_resp++;
`ifdef BT_RESP_TIMEOUT_EN
    if (resp_to)   obs_to++;
`endif
  end

  // reference model state
  int         exp_rdy  = 0;
  int         exp_fe   = 0;
  int         exp_resp = 0;
  int         exp_to   = 0;
  logic [7:0] exp_data = '0;
  logic       exp_ok   = 1'b0;
  logic       exp_err  = 1'b0;
  int         exp_len  = 0;
  int         m_len    = 0;
  byte        m_head[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("rdy_count",  obs_rdy, exp_rdy);
    chk("fe_count",   obs_fe, exp_fe);
    chk("resp_count", obs_resp, exp_resp);
    chk("rx_data",    {24'd0, rx_data}, {24'd0, exp_data});
    chk("resp_ok",    {31'd0, resp_ok}, {31'd0, exp_ok});
    chk("resp_err",   {31'd0, resp_err}, {31'd0, exp_err});
    chk("line_len",   {24'd0, line_len}, exp_len);
    chk("ok_err_excl", {31'd0, resp_ok & resp_err}, 32'd0);
`ifdef BT_RESP_TIMEOUT_EN
    chk("to_count",   obs_to, exp_to);
`endif
  endtask

  task automatic model_reset();
    exp_data = '0;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
    exp_len  = 0;
    m_len    = 0;
    m_head.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_fe++;
      return;
    end
    exp_rdy++;
    exp_data = b;
    if (b == 8'h0D) return;
    if (b == 8'h0A) begin
      if (m_len > 0) begin
        exp_resp++;
        exp_len = (m_len > 255) ? 255 : m_len;
        exp_ok  = (m_len >= 3) && (m_head[0] == "A") && (m_head[1] == "O") && (m_head[2] == "K");
        exp_err = (m_len >= 3) && (m_head[0] == "E") && (m_head[1] == "R") && (m_head[2] == "R");
        m_len   = 0;
        m_head.delete();
      end
      return;
    end
    if (m_head.size() < 3) m_head.push_back(b);
    m_len++;
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cyc(BAUD);
    end
    RX = stop_bit;
    wait_cyc(BAUD);
    RX = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    send_frame(b, good);
    model_byte(b, good);
    check_state();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    RX    = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string prefix;
    logic [7:0] ch;
    int n;

    RX    = 1'b1;
    rst_n = 1'b1;
    #1;
    do_reset();
    check_state();

    // single byte
    send_byte(8'h55, 1'b1);

    // short low glitch: false start, then a normal byte still decodes
    RX = 1'b0;
    wait_cyc(2);
    RX = 1'b1;
    wait_cyc(2 * BAUD);
    check_state();
    send_byte(8'hA3, 1'b1);

    // basic responses
    send_str("AOK\r\n");
    send_str("ERR\r\n");
    send_str("CONNECTED\r\n");
    send_str("\r\n");

    // framing error leaves rx_data and the partial line alone
    send_str("AO");
    send_byte(8'h3C, 1'b0);
    send_str("K\n");

    // reset in the middle of a frame and a line
    send_str("ER");
    RX = 1'b0;
    wait_cyc(3 * BAUD);
    rst_n = 1'b0;
    wait_cyc(3);
    RX    = 1'b1;
    rst_n = 1'b1;
    wait_cyc(2 * BAUD);
    model_reset();
    check_state();
    send_str("R\n");

    // line length saturation
    send_str("AOK");
    for (int i = 0; i < 297; i++) begin
      send_frame(8'h78, 1'b1);
      model_byte(8'h78, 1'b1);
    end
    check_state();
    send_str("\n");

    // long silence with a partial line pending
    send_str("AO");
    wait_cyc(20 * BAUD + 10);
`ifdef BT_RESP_TIMEOUT_EN
    exp_to++;
    m_len = 0;
    m_head.delete();
    check_state();
    send_str("AOK\n");
`else
    check_state();
    send_str("K\n");
`endif

    // randomized lines
    for (int l = 0; l < 30; l++) begin
      case ($urandom_range(0, 5))
        0: prefix = "AOK";
        1: prefix = "ERR";
        2: prefix = "AO";
        3: prefix = "ER";
        4: prefix = "AOX";
        default: prefix = "";
      endcase
      send_str(prefix);
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        ch = 8'($urandom_range(32'h20, 32'h7E));
        if ($urandom_range(0, 9) == 0) send_byte(ch, 1'b0);
        else send_byte(ch, 1'b1);
      end
      if ($urandom_range(0, 1) == 1) send_byte(8'h0D, 1'b1);
      send_byte(8'h0A, 1'b1);
      if ($urandom_range(0, 4) == 0) send_str("\r\n");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
